// File: rtl/ascon_pack.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_pack
//  Description : Shared Ascon types and constants. The permutation state is
//                five 64-bit words, S[0]..S[4], with S[0] at index 0.
//  Revision    : 1.0 - initial release
// ============================================================================
package ascon_pack;

   localparam int unsigned NB_WORDS  = 5;
   localparam int unsigned WORD_W    = 64;
   localparam int unsigned SBOX_W    = 5;

   typedef logic [0:NB_WORDS-1][WORD_W-1:0] type_state;

endpackage
`default_nettype wire

// File: rtl/sbox.sv
`default_nettype none
// ============================================================================
//  Module      : sbox
//  Description : 5-bit Ascon S-box, purely combinational lookup. Bit 4 of
//                x_i is the bit taken from state word S[0].
//  Revision    : 1.0 - initial release
// ============================================================================
module sbox
   import ascon_pack::*;
(
   input  logic [SBOX_W-1:0] x_i,
   output logic [SBOX_W-1:0] y_o
);

   // Table lookup of the substitution value
   always_comb begin
      y_o = 5'h00;
      case (x_i)
         5'h00: y_o = 5'h04;
         5'h01: y_o = 5'h0b;
         5'h02: y_o = 5'h1f;
         5'h03: y_o = 5'h14;
         5'h04: y_o = 5'h1a;
         5'h05: y_o = 5'h15;
         5'h06: y_o = 5'h09;
         5'h07: y_o = 5'h02;
         5'h08: y_o = 5'h1b;
         5'h09: y_o = 5'h05;
         5'h0a: y_o = 5'h08;
         5'h0b: y_o = 5'h12;
         5'h0c: y_o = 5'h1d;
         5'h0d: y_o = 5'h03;
         5'h0e: y_o = 5'h06;
         5'h0f: y_o = 5'h1c;
         5'h10: y_o = 5'h1e;
         5'h11: y_o = 5'h13;
         5'h12: y_o = 5'h07;
         5'h13: y_o = 5'h0e;
         5'h14: y_o = 5'h00;
         5'h15: y_o = 5'h0d;
         5'h16: y_o = 5'h11;
         5'h17: y_o = 5'h18;
         5'h18: y_o = 5'h10;
         5'h19: y_o = 5'h0c;
         5'h1a: y_o = 5'h01;
         5'h1b: y_o = 5'h19;
         5'h1c: y_o = 5'h16;
         5'h1d: y_o = 5'h0a;
         5'h1e: y_o = 5'h0f;
         5'h1f: y_o = 5'h17;
         default: y_o = 5'h00;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/substitution_layer.sv
`default_nettype none
// ============================================================================
//  Module      : substitution_layer
//  Description : Ascon p_S layer. Applies the 5-bit S-box to each of the 64
//                bit-slice columns of the state and registers the result
//                with a one-cycle valid flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module substitution_layer
   import ascon_pack::*;
(
   input  logic      clock_i,
   input  logic      resetb_i,
   input  logic      en_i,
   input  type_state sub_layer_i,
   output type_state sub_layer_o,
   output logic      valid_o
);

   type_state w_sub;
   type_state r_state;
   logic      r_valid;

   // One S-box per column; columns are independent so all run in parallel
   generate
      for (genvar i = 0; i < WORD_W; i++) begin : g_col
         logic [SBOX_W-1:0] w_x;
         logic [SBOX_W-1:0] w_y;

         assign w_x = {sub_layer_i[0][i], sub_layer_i[1][i], sub_layer_i[2][i],
                       sub_layer_i[3][i], sub_layer_i[4][i]};

         sbox u_sbox (
            .x_i (w_x),
            .y_o (w_y)
         );

         // MSB of the S-box output goes back to word S[0]
         for (genvar k = 0; k < NB_WORDS; k++) begin : g_bit
            assign w_sub[k][i] = w_y[SBOX_W-1-k];
         end
      end
   endgenerate

   // Output register: capture on enable, hold otherwise; valid marks a fresh capture
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         r_state <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= en_i;
         if (en_i) begin
            r_state <= w_sub;
         end
      end
   end

   assign sub_layer_o = r_state;
   assign valid_o     = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_substitution_layer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_substitution_layer
//  Description : Directed self-checking bench for substitution_layer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_substitution_layer;
   import ascon_pack::*;

   logic      clock_i;
   logic      resetb_i;
   logic      en_i;
   type_state sub_layer_i;
   type_state sub_layer_o;
   logic      valid_o;

   int n_total;
   int n_bad;

   substitution_layer u_dut (
      .clock_i     (clock_i),
      .resetb_i    (resetb_i),
      .en_i        (en_i),
      .sub_layer_i (sub_layer_i),
      .sub_layer_o (sub_layer_o),
      .valid_o     (valid_o)
   );

   // 10 ns clock
   initial clock_i = 1'b0;
   always #5 clock_i = ~clock_i;

   // Reference S-box table written out independently of the RTL
   logic [4:0] c_sb [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   function automatic type_state ref_ps(input type_state s);
      type_state  r;
      logic [4:0] x;
      logic [4:0] y;
      r = '0;
      for (int i = 0; i < 64; i++) begin
         x = {s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]};
         y = c_sb[x];
         for (int k = 0; k < 5; k++) r[k][i] = y[4-k];
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive one cycle of stimulus at the falling edge, return at the next falling edge
   task automatic step(input type_state s, input logic en);
      sub_layer_i = s;
      en_i        = en;
      @(negedge clock_i);
   endtask

   type_state  v_a;
   type_state  v_b;
   type_state  v_c;
   type_state  v_d;
   type_state  v_s;
   type_state  v_e;
   logic [4:0] v_x;
   logic [4:0] v_y;

   initial begin
      n_total     = 0;
      n_bad       = 0;
      resetb_i    = 1'b0;
      en_i        = 1'b0;
      sub_layer_i = '1;

      // Reset held across edges
      repeat (3) @(negedge clock_i);
      check("rst_state", sub_layer_o, '0);
      check("rst_valid", {319'b0, valid_o}, 320'd1 - 320'd1);
      resetb_i = 1'b1;
      @(negedge clock_i);
      check("idle_valid", {319'b0, valid_o}, '0);

      // All-zero state
      step('0, 1'b1);
      check("zero_s0", {256'b0, sub_layer_o[0]}, '0);
      check("zero_s1", {256'b0, sub_layer_o[1]}, '0);
      check("zero_s2", {256'b0, sub_layer_o[2]}, {256'b0, 64'hFFFF_FFFF_FFFF_FFFF});
      check("zero_s3", {256'b0, sub_layer_o[3]}, '0);
      check("zero_s4", {256'b0, sub_layer_o[4]}, '0);
      check("zero_valid", {319'b0, valid_o}, 320'd1);

      // All-ones state: SBOX[31] = 10111
      step('1, 1'b1);
      v_e = '1;
      v_e[1] = '0;
      check("ones_state", sub_layer_o, v_e);
      check("ones_valid", {319'b0, valid_o}, 320'd1);

      // Reference vector
      v_s[0] = 64'h8040_0c06_0000_0000;
      v_s[1] = 64'h8a55_114d_1cb6_a9a2;
      v_s[2] = 64'hbe26_3d4d_7aec_aa0f;
      v_s[3] = 64'h4ed0_ec0b_98c5_29b7;
      v_s[4] = 64'hc8cd_df37_bcd0_284a;
      step(v_s, 1'b1);
      check("vec_col63", {315'b0, sub_layer_o[0][63], sub_layer_o[1][63],
            sub_layer_o[2][63], sub_layer_o[3][63], sub_layer_o[4][63]}, 320'h0a);
      check("vec_full", sub_layer_o, ref_ps(v_s));

      // Exhaustive: same x in every column, expectation from the table directly
      for (int x = 0; x < 32; x++) begin
         v_x = x[4:0];
         v_y = c_sb[x];
         for (int k = 0; k < 5; k++) begin
            v_s[k] = {64{v_x[4-k]}};
            v_e[k] = {64{v_y[4-k]}};
         end
         step(v_s, 1'b1);
         check($sformatf("sweep_%0d", x), sub_layer_o, v_e);
      end

      // Walking pattern: a different x per neighbouring column
      for (int i = 0; i < 64; i++) begin
         v_x = 5'((i * 7 + 3) % 32);
         for (int k = 0; k < 5; k++) v_s[k][i] = v_x[4-k];
      end
      step(v_s, 1'b1);
      check("walk", sub_layer_o, ref_ps(v_s));

      // Hold: capture, then drop enable and change input
      v_a = {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210, 64'h0f0f_0f0f_f0f0_f0f0,
             64'h5555_aaaa_3333_cccc, 64'hdead_beef_cafe_f00d};
      step(v_a, 1'b1);
      check("hold_cap", sub_layer_o, ref_ps(v_a));
      step(~v_a, 1'b0);
      check("hold_state", sub_layer_o, ref_ps(v_a));
      check("hold_valid", {319'b0, valid_o}, '0);
      sub_layer_i = '0;
      @(negedge clock_i);
      check("hold_state2", sub_layer_o, ref_ps(v_a));

      // Back-to-back captures
      v_b = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_aaaa_bbbb_cccc,
             64'hdddd_eeee_ffff_0000, 64'h1357_9bdf_2468_ace0};
      v_c = ~v_b;
      v_d = {v_b[2], v_b[4], v_b[0], v_b[1], v_b[3]};
      step(v_b, 1'b1);
      check("b2b_1", sub_layer_o, ref_ps(v_b));
      check("b2b_1v", {319'b0, valid_o}, 320'd1);
      step(v_c, 1'b1);
      check("b2b_2", sub_layer_o, ref_ps(v_c));
      check("b2b_2v", {319'b0, valid_o}, 320'd1);
      step(v_d, 1'b1);
      check("b2b_3", sub_layer_o, ref_ps(v_d));
      check("b2b_3v", {319'b0, valid_o}, 320'd1);

      // Asynchronous reset between edges
      en_i = 1'b0;
      @(posedge clock_i);
      #2;
      resetb_i = 1'b0;
      #1;
      check("arst_state", sub_layer_o, '0);
      check("arst_valid", {319'b0, valid_o}, '0);
      @(negedge clock_i);
      resetb_i = 1'b1;
      @(negedge clock_i);
      check("post_rst", sub_layer_o, '0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
